// File: rtl/unidad_control_pipeline_pkg.sv
// Shared types and constants for the MIPS pipeline sequencer.
// Holds the state encoding, the per-cycle strobe bundle and its NOP value.
package unidad_control_pipeline_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    typedef struct packed {
        logic pipe_enable;
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NOP = '0;

    localparam int DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/unidad_control_pipeline_detector_load_use.sv
// Load-use hazard detector: a load in EX whose destination is read by the ID
// instruction, which forwarding cannot cover. Register 0 never creates a hazard.
module detector_load_use (
    input  logic       i_mem_read_EX,
    input  logic [4:0] i_rt_EX,
    input  logic [4:0] i_rs_ID,
    input  logic [4:0] i_rt_ID,
    input  logic       i_uses_rt_ID,
    output logic       o_stall
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit  = (i_rt_EX == i_rs_ID);
    assign rt_hit  = i_uses_rt_ID && (i_rt_EX == i_rt_ID);
    assign o_stall = i_mem_read_EX && (i_rt_EX != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/unidad_control_pipeline.sv
// Pipeline sequencer: start/run/step/drain/halt, load-use stalls, branch flushes
// and a saturating count of advancing cycles for the debug unit.
module unidad_control_pipeline
    import unidad_control_pipeline_pkg::*;
#(
    parameter int CYCLE_W      = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_debug_mode,
    input  logic               i_step,
    input  logic               i_mem_read_EX,
    input  logic [4:0]         i_rt_EX,
    input  logic [4:0]         i_rs_ID,
    input  logic [4:0]         i_rt_ID,
    input  logic               i_uses_rt_ID,
    input  logic               i_branch_taken_ID,
    input  logic               i_halt_ID,
    output logic               o_pipe_enable,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic               o_if_id_flush,
    output logic               o_id_ex_bubble,
    output logic               o_running,
    output logic               o_halted,
    output logic [CYCLE_W-1:0] o_cycle_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t             state_q, state_d;
    logic               step_q, step_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CYCLE_W-1:0] count_q;
    logic               adv;
    logic               load_use;
    pipe_ctrl_t         ctrl;

    detector_load_use u_detector_load_use (
        .i_mem_read_EX (i_mem_read_EX),
        .i_rt_EX       (i_rt_EX),
        .i_rs_ID       (i_rs_ID),
        .i_rt_ID       (i_rt_ID),
        .i_uses_rt_ID  (i_uses_rt_ID),
        .o_stall       (load_use)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            step_q  <= 1'b0;
            drain_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            drain_q <= drain_d;
            if (adv && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        drain_d = drain_q;
        adv     = 1'b0;
        ctrl    = CTRL_NOP;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = i_debug_mode ? ST_STEP_WAIT : ST_RUN;
                    step_d  = i_debug_mode;
                end
            end
            ST_RUN, ST_STEP_WAIT: begin
                adv = (state_q == ST_RUN) || i_step;
                if (adv) begin
                    ctrl.pipe_enable = 1'b1;
                    // A stall masks halt and branch; both are seen again next adv cycle.
                    if (load_use) begin
                        ctrl.id_ex_bubble = 1'b1;
                    end else if (i_halt_ID) begin
                        ctrl.if_id_write = 1'b1;
                        ctrl.if_id_flush = 1'b1;
                        drain_d          = DRAIN_W'(DRAIN_CYCLES);
                        state_d          = ST_DRAIN;
                    end else if (i_branch_taken_ID) begin
                        ctrl.pc_write    = 1'b1;
                        ctrl.if_id_write = 1'b1;
                        ctrl.if_id_flush = 1'b1;
                    end else begin
                        ctrl.pc_write    = 1'b1;
                        ctrl.if_id_write = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                adv = step_q ? i_step : 1'b1;
                if (adv) begin
                    ctrl.pipe_enable = 1'b1;
                    ctrl.if_id_flush = 1'b1;
                    drain_d          = drain_q - 1'b1;
                    if (drain_q == DRAIN_W'(1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_pipe_enable  = ctrl.pipe_enable;
    assign o_pc_write     = ctrl.pc_write;
    assign o_if_id_write  = ctrl.if_id_write;
    assign o_if_id_flush  = ctrl.if_id_flush;
    assign o_id_ex_bubble = ctrl.id_ex_bubble;
    assign o_running      = (state_q == ST_RUN) || (state_q == ST_STEP_WAIT) ||
                            (state_q == ST_DRAIN);
    assign o_halted       = (state_q == ST_HALTED);
    assign o_cycle_count  = count_q;

endmodule

// File: tb/tb_unidad_control_pipeline.sv
// Directed bench for the pipeline sequencer; a second instance with a 4-bit
// counter covers saturation.
module tb_unidad_control_pipeline;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_debug_mode = 1'b0;
    logic        i_step = 1'b0;
    logic        i_mem_read_EX = 1'b0;
    logic [4:0]  i_rt_EX = '0;
    logic [4:0]  i_rs_ID = '0;
    logic [4:0]  i_rt_ID = '0;
    logic        i_uses_rt_ID = 1'b0;
    logic        i_branch_taken_ID = 1'b0;
    logic        i_halt_ID = 1'b0;

    logic        o_pipe_enable, o_pc_write, o_if_id_write, o_if_id_flush;
    logic        o_id_ex_bubble, o_running, o_halted;
    logic [31:0] o_cycle_count;

    logic        s_pipe_enable, s_pc_write, s_if_id_write, s_if_id_flush;
    logic        s_id_ex_bubble, s_running, s_halted;
    logic [3:0]  s_cycle_count;

    logic [6:0]  outs;
    int          total = 0;
    int          bad = 0;

    // {pipe_enable, pc_write, if_id_write, flush, bubble, running, halted}
    localparam logic [6:0] O_IDLE   = 7'b0000000;
    localparam logic [6:0] O_RUN    = 7'b1110010;
    localparam logic [6:0] O_STALL  = 7'b1000110;
    localparam logic [6:0] O_BRANCH = 7'b1111010;
    localparam logic [6:0] O_HALT   = 7'b1011010;
    localparam logic [6:0] O_DRAIN  = 7'b1001010;
    localparam logic [6:0] O_WAIT   = 7'b0000010;
    localparam logic [6:0] O_HALTED = 7'b0000001;

    assign outs = {o_pipe_enable, o_pc_write, o_if_id_write, o_if_id_flush,
                   o_id_ex_bubble, o_running, o_halted};

    always #5 i_clk = ~i_clk;

    unidad_control_pipeline dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_start           (i_start),
        .i_debug_mode      (i_debug_mode),
        .i_step            (i_step),
        .i_mem_read_EX     (i_mem_read_EX),
        .i_rt_EX           (i_rt_EX),
        .i_rs_ID           (i_rs_ID),
        .i_rt_ID           (i_rt_ID),
        .i_uses_rt_ID      (i_uses_rt_ID),
        .i_branch_taken_ID (i_branch_taken_ID),
        .i_halt_ID         (i_halt_ID),
        .o_pipe_enable     (o_pipe_enable),
        .o_pc_write        (o_pc_write),
        .o_if_id_write     (o_if_id_write),
        .o_if_id_flush     (o_if_id_flush),
        .o_id_ex_bubble    (o_id_ex_bubble),
        .o_running         (o_running),
        .o_halted          (o_halted),
        .o_cycle_count     (o_cycle_count)
    );

    unidad_control_pipeline #(.CYCLE_W(4)) dut_small (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_start           (i_start),
        .i_debug_mode      (i_debug_mode),
        .i_step            (i_step),
        .i_mem_read_EX     (i_mem_read_EX),
        .i_rt_EX           (i_rt_EX),
        .i_rs_ID           (i_rs_ID),
        .i_rt_ID           (i_rt_ID),
        .i_uses_rt_ID      (i_uses_rt_ID),
        .i_branch_taken_ID (i_branch_taken_ID),
        .i_halt_ID         (i_halt_ID),
        .o_pipe_enable     (s_pipe_enable),
        .o_pc_write        (s_pc_write),
        .o_if_id_write     (s_if_id_write),
        .o_if_id_flush     (s_if_id_flush),
        .o_id_ex_bubble    (s_id_ex_bubble),
        .o_running         (s_running),
        .o_halted          (s_halted),
        .o_cycle_count     (s_cycle_count)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_start = 0; i_debug_mode = 0; i_step = 0; i_mem_read_EX = 0;
        i_rt_EX = 0; i_rs_ID = 0; i_rt_ID = 0; i_uses_rt_ID = 0;
        i_branch_taken_ID = 0; i_halt_ID = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_reset = 0;
        tick();
        total++;
        if (outs !== O_IDLE || o_cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_low outs=%b count=%0d want outs=%b count=0", outs, o_cycle_count, O_IDLE);
        end
        i_reset = 1;
        #1;
        total++;
        if (outs !== O_IDLE || o_cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_release outs=%b count=%0d want outs=%b count=0", outs, o_cycle_count, O_IDLE);
        end
        tick();
    endtask

    task automatic test_start_run();
        i_start = 1;
        i_debug_mode = 0;
        tick();
        i_start = 0;
        #1;
        total++;
        if (outs !== O_RUN || o_cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL start_run outs=%b count=%0d want outs=%b count=0", outs, o_cycle_count, O_RUN);
        end
        tick();
        total++;
        if (o_cycle_count !== 32'd1) begin
            bad++;
            $display("FAIL run_count1 got=%0d want=1", o_cycle_count);
        end
        tick();
        total++;
        if (o_cycle_count !== 32'd2 || outs !== O_RUN) begin
            bad++;
            $display("FAIL run_count2 got=%0d outs=%b want=2 outs=%b", o_cycle_count, outs, O_RUN);
        end
    endtask

    task automatic test_load_use();
        // {mem_read, rt_EX, rs_ID, rt_ID, uses_rt, expect_stall}
        logic [17:0] vec [5];
        vec[0] = {1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1};
        vec[1] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        vec[2] = {1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0};
        vec[3] = {1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1};
        vec[4] = {1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            {i_mem_read_EX, i_rt_EX, i_rs_ID, i_rt_ID, i_uses_rt_ID} = vec[i][17:1];
            #1;
            total++;
            if (outs !== (vec[i][0] ? O_STALL : O_RUN)) begin
                bad++;
                $display("FAIL load_use[%0d] outs=%b want=%b", i, outs, vec[i][0] ? O_STALL : O_RUN);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        i_branch_taken_ID = 1;
        #1;
        total++;
        if (outs !== O_BRANCH) begin
            bad++;
            $display("FAIL branch outs=%b want=%b", outs, O_BRANCH);
        end
        tick();
        i_mem_read_EX = 1; i_rt_EX = 5; i_rs_ID = 5;
        #1;
        total++;
        if (outs !== O_STALL) begin
            bad++;
            $display("FAIL branch_stall outs=%b want=%b", outs, O_STALL);
        end
        tick();
        i_branch_taken_ID = 0;
        i_halt_ID = 1;
        #1;
        total++;
        if (outs !== O_STALL) begin
            bad++;
            $display("FAIL halt_stall outs=%b want=%b", outs, O_STALL);
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if (outs !== O_RUN || o_cycle_count !== 32'd10) begin
            bad++;
            $display("FAIL after_halt_stall outs=%b count=%0d want outs=%b count=10", outs, o_cycle_count, O_RUN);
        end
    endtask

    task automatic test_halt_drain();
        i_halt_ID = 1;
        #1;
        total++;
        if (outs !== O_HALT) begin
            bad++;
            $display("FAIL halt_accept outs=%b want=%b", outs, O_HALT);
        end
        tick();
        i_halt_ID = 0;
        i_branch_taken_ID = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (outs !== O_DRAIN) begin
                bad++;
                $display("FAIL drain[%0d] outs=%b want=%b", i, outs, O_DRAIN);
            end
            tick();
        end
        clear_inputs();
        i_start = 1;
        #1;
        total++;
        if (outs !== O_HALTED || o_cycle_count !== 32'd14) begin
            bad++;
            $display("FAIL halted outs=%b count=%0d want outs=%b count=14", outs, o_cycle_count, O_HALTED);
        end
        tick();
        tick();
        i_start = 0;
        total++;
        if (outs !== O_HALTED || o_cycle_count !== 32'd14) begin
            bad++;
            $display("FAIL halted_start_ignored outs=%b count=%0d want outs=%b count=14", outs, o_cycle_count, O_HALTED);
        end
    endtask

    task automatic test_step_mode();
        i_reset = 0;
        tick();
        i_reset = 1;
        tick();
        i_start = 1;
        i_debug_mode = 1;
        tick();
        i_start = 0;
        i_debug_mode = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (outs !== O_WAIT || o_cycle_count !== 32'd0) begin
                bad++;
                $display("FAIL step_idle[%0d] outs=%b count=%0d want outs=%b count=0", i, outs, o_cycle_count, O_WAIT);
            end
            tick();
        end
        i_step = 1;
        #1;
        total++;
        if (outs !== O_RUN) begin
            bad++;
            $display("FAIL step_pulse outs=%b want=%b", outs, O_RUN);
        end
        tick();
        i_step = 0;
        #1;
        total++;
        if (outs !== O_WAIT || o_cycle_count !== 32'd1) begin
            bad++;
            $display("FAIL step_after outs=%b count=%0d want outs=%b count=1", outs, o_cycle_count, O_WAIT);
        end
        i_step = 1;
        i_halt_ID = 1;
        #1;
        total++;
        if (outs !== O_HALT) begin
            bad++;
            $display("FAIL step_halt outs=%b want=%b", outs, O_HALT);
        end
        tick();
        i_halt_ID = 0;
        for (int i = 0; i < 3; i++) begin
            i_step = 0;
            #1;
            total++;
            if (outs !== O_WAIT) begin
                bad++;
                $display("FAIL step_drain_wait[%0d] outs=%b want=%b", i, outs, O_WAIT);
            end
            i_step = 1;
            #1;
            total++;
            if (outs !== O_DRAIN) begin
                bad++;
                $display("FAIL step_drain[%0d] outs=%b want=%b", i, outs, O_DRAIN);
            end
            tick();
        end
        i_step = 0;
        #1;
        total++;
        if (outs !== O_HALTED || o_cycle_count !== 32'd5) begin
            bad++;
            $display("FAIL step_halted outs=%b count=%0d want outs=%b count=5", outs, o_cycle_count, O_HALTED);
        end
    endtask

    task automatic test_async_reset_saturation();
        i_reset = 0;
        tick();
        i_reset = 1;
        tick();
        i_start = 1;
        tick();
        i_start = 0;
        i_halt_ID = 1;
        tick();
        i_halt_ID = 0;
        tick();
        #2;
        total++;
        if (outs !== O_DRAIN) begin
            bad++;
            $display("FAIL pre_reset_drain outs=%b want=%b", outs, O_DRAIN);
        end
        i_reset = 0;
        #1;
        total++;
        if (outs !== O_IDLE || o_cycle_count !== 32'd0 || s_cycle_count !== 4'd0) begin
            bad++;
            $display("FAIL async_reset outs=%b count=%0d small=%0d want outs=%b counts=0", outs, o_cycle_count, s_cycle_count, O_IDLE);
        end
        tick();
        i_reset = 1;
        tick();
        i_start = 1;
        tick();
        i_start = 0;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (o_cycle_count !== 32'd20 || s_cycle_count !== 4'd15 || s_running !== 1'b1) begin
            bad++;
            $display("FAIL saturation count=%0d small=%0d run=%b want count=20 small=15 run=1", o_cycle_count, s_cycle_count, s_running);
        end
    endtask

    initial begin
        test_reset();
        test_start_run();
        test_load_use();
        test_branch();
        test_halt_drain();
        test_step_mode();
        test_async_reset_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
